rv_rf_ctrl: RTL

Controller placed between the pipeline/debug unit and the 32x64 register file (synchronous write, registered read with 1-cycle latency, no reset on the storage). After reset it zero-initialises the whole array. It then arbitrates the single write port between writeback and a debug port, and shares read port 2 with debug reads. It also forces x0 to read as zero and supplies same-cycle write-to-read bypass, because the RF returns old data when a read and a write to the same address coincide.

---
 rtl/rv_pkg.sv | 13 +
 rtl/rv_rf_bypass.sv | 50 +++++
 rtl/rv_rf_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared sizing constants and controller state encoding for the register-file slice.
package rv_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rv_rf_bypass.sv
// Per-read-port result stage: x0 forcing and write-to-read forwarding over the
// registered RF read, which returns stale data on a same-cycle collision.
module rv_rf_bypass
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int AW   = rv_pkg::AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            force_zero_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [XLEN-1:0] rf_rdata_i,
  output logic [XLEN-1:0] data_o
);

  logic            hit_r;
  logic            zero_r;
  logic [XLEN-1:0] wdata_r;

  // Capture the collision, x0 and forwarded-data state alongside the RF read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_r   <= 1'b0;
      zero_r  <= 1'b0;
      wdata_r <= {XLEN{1'b0}};
    end else begin
      hit_r   <= wr_en_i && (wr_addr_i == rd_addr_i) &&
                 (rd_addr_i != {AW{1'b0}}) && !force_zero_i;
      zero_r  <= (rd_addr_i == {AW{1'b0}}) || force_zero_i;
      wdata_r <= wr_data_i;
    end
  end

  // Select the architectural result for the read issued last cycle.
  always_comb begin
    data_o = rf_rdata_i;
    if (zero_r) begin
      data_o = {XLEN{1'b0}};
    end else if (hit_r) begin
      data_o = wdata_r;
    end else begin
      data_o = rf_rdata_i;
    end
  end

endmodule

// File: rtl/rv_rf_ctrl.sv
// Register-file controller: zeroes the array after reset, then arbitrates the
// write port (writeback over debug) and shares read port 2 with debug reads.
module rv_rf_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN    = rv_pkg::XLEN,
  parameter int NREG    = rv_pkg::NREG,
  parameter int AW      = rv_pkg::AW,
  parameter bit INIT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  input  logic            rs2_en_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            wb_en_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            dbg_req_i,
  input  logic            dbg_we_i,
  input  logic [AW-1:0]   dbg_addr_i,
  input  logic [XLEN-1:0] dbg_wdata_i,
  output logic            dbg_gnt_o,
  output logic            dbg_rvalid_o,
  output logic [XLEN-1:0] dbg_rdata_o,
  output logic            init_done_o,
  output logic [AW-1:0]   rf_rd_reg1_o,
  output logic [AW-1:0]   rf_rd_reg2_o,
  input  logic [XLEN-1:0] rf_rd_reg1_i,
  input  logic [XLEN-1:0] rf_rd_reg2_i,
  output logic [AW-1:0]   rf_wr_reg_o,
  output logic [XLEN-1:0] rf_wr_data_o,
  output logic            rf_wr_en_o
);

  state_e          state_r;
  logic [AW-1:0]   cnt_r;
  logic            init_done_r;
  logic            dbg_rvalid_r;
  logic [XLEN-1:0] dbg_hold_r;

  logic            run_s;
  logic            dbg_wr_gnt_s;
  logic            dbg_rd_gnt_s;
  logic            wr_en_s;
  logic [AW-1:0]   wr_reg_s;
  logic [XLEN-1:0] wr_data_s;
  logic [XLEN-1:0] rs1_byp_s;
  logic [XLEN-1:0] rs2_byp_s;

  assign run_s        = (state_r == ST_RUN);
  assign dbg_wr_gnt_s = run_s && dbg_req_i && dbg_we_i && !wb_en_i;
  assign dbg_rd_gnt_s = run_s && dbg_req_i && !dbg_we_i && !rs2_en_i;
  assign dbg_gnt_o    = dbg_wr_gnt_s || dbg_rd_gnt_s;

  // Write-port source: zeroing sweep, then writeback, then debug; x0 never written in RUN.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_reg_s  = {AW{1'b0}};
    wr_data_s = {XLEN{1'b0}};
    if (!run_s) begin
      wr_en_s   = 1'b1;
      wr_reg_s  = cnt_r;
      wr_data_s = {XLEN{1'b0}};
    end else if (wb_en_i) begin
      wr_en_s   = (wb_addr_i != {AW{1'b0}});
      wr_reg_s  = wb_addr_i;
      wr_data_s = wb_data_i;
    end else if (dbg_wr_gnt_s) begin
      wr_en_s   = (dbg_addr_i != {AW{1'b0}});
      wr_reg_s  = dbg_addr_i;
      wr_data_s = dbg_wdata_i;
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  assign rf_wr_en_o   = wr_en_s;
  assign rf_wr_reg_o  = wr_reg_s;
  assign rf_wr_data_o = wr_data_s;
  assign rf_rd_reg1_o = rs1_addr_i;
  assign rf_rd_reg2_o = dbg_rd_gnt_s ? dbg_addr_i : rs2_addr_i;

  // Zeroing sequencer; init_done follows the transition into RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= INIT_EN ? ST_INIT : ST_RUN;
      cnt_r       <= {AW{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          cnt_r <= cnt_r + AW'(1);
          if (cnt_r == AW'(NREG - 1)) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end
        end
        ST_RUN: begin
          init_done_r <= 1'b1;
        end
        default: begin
          state_r <= ST_INIT;
          cnt_r   <= {AW{1'b0}};
        end
      endcase
    end
  end

  assign init_done_o = init_done_r;

  rv_rf_bypass #(.XLEN(XLEN), .AW(AW)) u_byp1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .force_zero_i (!run_s),
    .rd_addr_i    (rf_rd_reg1_o),
    .wr_en_i      (wr_en_s),
    .wr_addr_i    (wr_reg_s),
    .wr_data_i    (wr_data_s),
    .rf_rdata_i   (rf_rd_reg1_i),
    .data_o       (rs1_byp_s)
  );

  rv_rf_bypass #(.XLEN(XLEN), .AW(AW)) u_byp2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .force_zero_i (!run_s),
    .rd_addr_i    (rf_rd_reg2_o),
    .wr_en_i      (wr_en_s),
    .wr_addr_i    (wr_reg_s),
    .wr_data_i    (wr_data_s),
    .rf_rdata_i   (rf_rd_reg2_i),
    .data_o       (rs2_byp_s)
  );

  assign rs1_data_o = run_s ? rs1_byp_s : {XLEN{1'b0}};
  assign rs2_data_o = run_s ? rs2_byp_s : {XLEN{1'b0}};

  // Debug read response: valid one cycle after grant, data held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rvalid_r <= 1'b0;
      dbg_hold_r   <= {XLEN{1'b0}};
    end else begin
      dbg_rvalid_r <= dbg_rd_gnt_s;
      if (dbg_rvalid_r) begin
        dbg_hold_r <= rs2_byp_s;
      end
    end
  end

  assign dbg_rvalid_o = dbg_rvalid_r;
  assign dbg_rdata_o  = dbg_rvalid_r ? rs2_byp_s : dbg_hold_r;

endmodule
